host_ram_responder: RTL and testbench

Responder end of the host→GPU RAM request interface. It accepts one-shot write pulses and read requests from the Z80 bus bridge, queues writes, and arbitrates for the shared GPU RAM port B against a busy signal from the other RAM masters. It executes each access and, for reads, returns the byte with a one-shot ready pulse. Accesses at or above the top of physical GPU RAM never touch the RAM; such reads return a fixed fill byte.

---
 rtl/gpu_bus_pkg.sv | 19 +
 rtl/host_wr_fifo.sv | 47 ++++
 rtl/host_ram_responder.sv | 122 ++++++++++++
 tb/tb_host_ram_responder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_bus_pkg.sv
// Shared types and constants for the host-to-GPU RAM request path.
package gpu_bus_pkg;

   localparam int ADDR_W = 20;
   localparam logic [7:0] OOB_DATA_DEF = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WRITE     = 2'd1,
      ST_READ_WAIT = 2'd2,
      ST_RESPOND   = 2'd3
   } resp_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [7:0]        data;
   } wr_entry_t;

endpackage

// File: rtl/host_wr_fifo.sv
// Synchronous write-entry FIFO; a push on a full queue succeeds when a pop happens in the same cycle.
module host_wr_fifo
   import gpu_bus_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      GPU_CLK,
   input  logic      reset,
   input  logic      push,
   input  logic      pop,
   input  wr_entry_t din,
   output wr_entry_t dout,
   output logic      full,
   output logic      empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   wr_entry_t   mem [DEPTH];
   logic [AW:0] wptr;
   logic [AW:0] rptr;
   logic        do_pop;
   logic        do_push;

   // Pointers carry one extra wrap bit to tell full from empty.
   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rptr[AW-1:0]];

   always_ff @(posedge GPU_CLK) begin
      if (!reset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + PTR_ONE;
         if (do_pop)  rptr <= rptr + PTR_ONE;
      end
   end

   always_ff @(posedge GPU_CLK) begin
      if (do_push) mem[wptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/host_ram_responder.sv
// Host-side responder for GPU RAM port B: queues writes, holds one read, arbitrates against ram_busy.
module host_ram_responder
   import gpu_bus_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RAM_TOP      = 20'h08000,
   parameter int                READ_LATENCY = 2,
   parameter int                WFIFO_DEPTH  = 4,
   parameter logic [7:0]        OOB_DATA     = OOB_DATA_DEF
) (
   input  logic              GPU_CLK,
   input  logic              reset,
   input  logic              host_wr_ena,
   input  logic              host_rd_req,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [7:0]        host_wdata,
   output logic [7:0]        host_rData,
   output logic              host_rd_rdy,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_wdata,
   output logic              ram_we,
   input  logic [7:0]        ram_rdata,
   input  logic              ram_busy,
   output logic              wr_overflow,
   output logic              rd_collision
);

   resp_state_t       state;
   logic              rd_valid;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_oob;
   logic [2:0]        rd_cnt;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_pop;
   wr_entry_t         fifo_in;
   wr_entry_t         fifo_head;

   assign fifo_in  = '{addr: host_addr, data: host_wdata};
   assign fifo_pop = (state == ST_IDLE) && !ram_busy && !fifo_empty;

   host_wr_fifo #(.DEPTH(WFIFO_DEPTH)) u_wr_fifo (
      .GPU_CLK (GPU_CLK),
      .reset   (reset),
      .push    (host_wr_ena),
      .pop     (fifo_pop),
      .din     (fifo_in),
      .dout    (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge GPU_CLK) begin
      if (!reset) begin
         state        <= ST_IDLE;
         rd_valid     <= 1'b0;
         rd_addr      <= '0;
         rd_oob       <= 1'b0;
         rd_cnt       <= '0;
         ram_addr     <= '0;
         ram_wdata    <= '0;
         ram_we       <= 1'b0;
         host_rData   <= '0;
         host_rd_rdy  <= 1'b0;
         wr_overflow  <= 1'b0;
         rd_collision <= 1'b0;
      end else begin
         ram_we      <= 1'b0;
         host_rd_rdy <= 1'b0;

         if (host_wr_ena && fifo_full && !fifo_pop) wr_overflow <= 1'b1;

         if (host_rd_req) begin
            if (rd_valid) begin
               rd_collision <= 1'b1;
            end else begin
               rd_valid <= 1'b1;
               rd_addr  <= host_addr;
            end
         end

         case (state)
            ST_IDLE: begin
               // Writes drain first so a pending read observes every earlier write.
               if (!ram_busy) begin
                  if (!fifo_empty) begin
                     if (fifo_head.addr < RAM_TOP) begin
                        ram_addr  <= fifo_head.addr;
                        ram_wdata <= fifo_head.data;
                        ram_we    <= 1'b1;
                        state     <= ST_WRITE;
                     end
                  end else if (rd_valid) begin
                     if (rd_addr < RAM_TOP) begin
                        ram_addr <= rd_addr;
                        rd_cnt   <= 3'(READ_LATENCY);
                        rd_oob   <= 1'b0;
                        state    <= ST_READ_WAIT;
                     end else begin
                        rd_oob <= 1'b1;
                        state  <= ST_RESPOND;
                     end
                  end
               end
            end
            ST_WRITE: state <= ST_IDLE;
            ST_READ_WAIT: begin
               // Counter reaches zero as RESPOND begins, the cycle ram_rdata becomes valid.
               rd_cnt <= rd_cnt - 3'd1;
               if (rd_cnt == 3'd1) state <= ST_RESPOND;
            end
            ST_RESPOND: begin
               host_rData  <= rd_oob ? OOB_DATA : ram_rdata;
               host_rd_rdy <= 1'b1;
               rd_valid    <= 1'b0;
               state       <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_host_ram_responder.sv
// Directed bench for host_ram_responder with a two-cycle-latency RAM model.
module tb_host_ram_responder;

   logic        GPU_CLK = 1'b0;
   logic        reset = 1'b0;
   logic        host_wr_ena = 1'b0;
   logic        host_rd_req = 1'b0;
   logic [19:0] host_addr = '0;
   logic [7:0]  host_wdata = '0;
   logic [7:0]  host_rData;
   logic        host_rd_rdy;
   logic [19:0] ram_addr;
   logic [7:0]  ram_wdata;
   logic        ram_we;
   logic [7:0]  ram_rdata;
   logic        ram_busy = 1'b0;
   logic        wr_overflow;
   logic        rd_collision;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int last_n = 0;

   logic [27:0] we_log[$];
   int          we_cyc_q[$];
   logic [27:0] exp_q[$];
   int          rdy_count = 0;
   int          rdy_cyc = -1;
   logic [7:0]  rdy_data = '0;

   logic [7:0] mem [0:32767];
   logic [7:0] p1;
   logic [7:0] p2;

   host_ram_responder dut (
      .GPU_CLK      (GPU_CLK),
      .reset        (reset),
      .host_wr_ena  (host_wr_ena),
      .host_rd_req  (host_rd_req),
      .host_addr    (host_addr),
      .host_wdata   (host_wdata),
      .host_rData   (host_rData),
      .host_rd_rdy  (host_rd_rdy),
      .ram_addr     (ram_addr),
      .ram_wdata    (ram_wdata),
      .ram_we       (ram_we),
      .ram_rdata    (ram_rdata),
      .ram_busy     (ram_busy),
      .wr_overflow  (wr_overflow),
      .rd_collision (rd_collision)
   );

   // ---------------- clock / cycle count ----------------
   always #4 GPU_CLK = ~GPU_CLK;
   always @(posedge GPU_CLK) cyc <= cyc + 1;

   // ---------------- RAM model: data valid two cycles after address ----------------
   always @(posedge GPU_CLK) begin
      if (ram_we && ram_addr < 20'h08000) mem[ram_addr[14:0]] <= ram_wdata;
      p1 <= mem[ram_addr[14:0]];
      p2 <= p1;
   end
   assign ram_rdata = p2;

   // ---------------- output monitor ----------------
   always @(negedge GPU_CLK) begin
      if (ram_we) begin
         we_log.push_back({ram_addr, ram_wdata});
         we_cyc_q.push_back(cyc);
      end
      if (host_rd_rdy) begin
         rdy_count = rdy_count + 1;
         rdy_cyc   = cyc;
         rdy_data  = host_rData;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic clear_logs();
      we_log.delete();
      we_cyc_q.delete();
      exp_q.delete();
      rdy_count = 0;
      rdy_cyc   = -1;
   endtask

   task automatic apply_reset();
      @(posedge GPU_CLK); #1;
      reset = 1'b0;
      repeat (3) @(posedge GPU_CLK);
      #1 reset = 1'b1;
      clear_logs();
   endtask

   task automatic strobe(input logic wr, input logic rd, input logic [19:0] a, input logic [7:0] d);
      @(posedge GPU_CLK); #1;
      host_wr_ena = wr;
      host_rd_req = rd;
      host_addr   = a;
      host_wdata  = d;
      last_n      = cyc;
      @(posedge GPU_CLK); #1;
      host_wr_ena = 1'b0;
      host_rd_req = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge GPU_CLK);
      @(negedge GPU_CLK);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      apply_reset();
      @(negedge GPU_CLK);
      n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
      n_cmp++; if (host_rd_rdy !== 1'b0) begin n_err++; $display("FAIL reset_rd_rdy: got %b want 0", host_rd_rdy); end
      n_cmp++; if (ram_addr !== 20'h0) begin n_err++; $display("FAIL reset_ram_addr: got %h want 0", ram_addr); end
      n_cmp++; if (ram_wdata !== 8'h0) begin n_err++; $display("FAIL reset_ram_wdata: got %h want 0", ram_wdata); end
      n_cmp++; if (host_rData !== 8'h0) begin n_err++; $display("FAIL reset_rData: got %h want 0", host_rData); end
      n_cmp++; if (wr_overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", wr_overflow); end
      n_cmp++; if (rd_collision !== 1'b0) begin n_err++; $display("FAIL reset_collision: got %b want 0", rd_collision); end
   endtask

   task automatic test_write();
      int n;
      apply_reset();
      strobe(1'b1, 1'b0, 20'h00010, 8'hA5);
      n = last_n;
      wait_cycles(6);
      n_cmp++;
      if (we_log.size() != 1) begin
         n_err++; $display("FAIL write_pulses: got %0d want 1", we_log.size());
      end else begin
         n_cmp++; if (we_log[0] !== {20'h00010, 8'hA5}) begin n_err++; $display("FAIL write_entry: got %h want %h", we_log[0], {20'h00010, 8'hA5}); end
         n_cmp++; if (we_cyc_q[0] != n + 2) begin n_err++; $display("FAIL write_latency: got cycle %0d want %0d", we_cyc_q[0], n + 2); end
      end
   endtask

   task automatic test_read();
      int n;
      apply_reset();
      strobe(1'b0, 1'b1, 20'h00123, 8'h00);
      n = last_n;
      wait_cycles(8);
      n_cmp++; if (rdy_count != 1) begin n_err++; $display("FAIL read_pulses: got %0d want 1", rdy_count); end
      n_cmp++; if (rdy_cyc != n + 5) begin n_err++; $display("FAIL read_latency: got cycle %0d want %0d", rdy_cyc, n + 5); end
      n_cmp++; if (rdy_data !== 8'h3C) begin n_err++; $display("FAIL read_data: got %h want 3c", rdy_data); end
      n_cmp++; if (host_rData !== 8'h3C) begin n_err++; $display("FAIL read_hold: got %h want 3c", host_rData); end
   endtask

   task automatic test_write_then_read();
      int n;
      apply_reset();
      strobe(1'b1, 1'b1, 20'h00040, 8'h77);
      n = last_n;
      wait_cycles(10);
      n_cmp++;
      if (we_cyc_q.size() != 1) begin
         n_err++; $display("FAIL wr_rd_pulses: got %0d want 1", we_cyc_q.size());
      end else begin
         n_cmp++; if (we_cyc_q[0] != n + 2) begin n_err++; $display("FAIL wr_rd_we_cycle: got %0d want %0d", we_cyc_q[0], n + 2); end
      end
      n_cmp++; if (rdy_cyc != n + 7) begin n_err++; $display("FAIL wr_rd_rdy_cycle: got %0d want %0d", rdy_cyc, n + 7); end
      n_cmp++; if (rdy_data !== 8'h77) begin n_err++; $display("FAIL wr_rd_data: got %h want 77", rdy_data); end
   endtask

   task automatic test_out_of_range();
      int n;
      apply_reset();
      strobe(1'b1, 1'b0, 20'h09000, 8'h55);
      wait_cycles(4);
      strobe(1'b0, 1'b1, 20'h08000, 8'h00);
      n = last_n;
      wait_cycles(6);
      n_cmp++; if (rdy_count != 1) begin n_err++; $display("FAIL oob_pulses: got %0d want 1", rdy_count); end
      n_cmp++; if (rdy_cyc != n + 3) begin n_err++; $display("FAIL oob_latency: got cycle %0d want %0d", rdy_cyc, n + 3); end
      n_cmp++; if (rdy_data !== 8'hFF) begin n_err++; $display("FAIL oob_data: got %h want ff", rdy_data); end
      n_cmp++; if (we_log.size() != 0) begin n_err++; $display("FAIL oob_no_write: got %0d pulses want 0", we_log.size()); end
   endtask

   task automatic test_busy_overflow();
      apply_reset();
      ram_busy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i < 4) exp_q.push_back({20'h00100 + 20'(i), 8'h10 + 8'(i)});
         strobe(1'b1, 1'b0, 20'h00100 + 20'(i), 8'h10 + 8'(i));
      end
      @(negedge GPU_CLK);
      n_cmp++; if (wr_overflow !== 1'b1) begin n_err++; $display("FAIL busy_overflow: got %b want 1", wr_overflow); end
      n_cmp++; if (we_log.size() != 0) begin n_err++; $display("FAIL busy_hold: got %0d pulses want 0", we_log.size()); end
      @(posedge GPU_CLK); #1 ram_busy = 1'b0;
      wait_cycles(14);
      n_cmp++;
      if (we_log.size() != 4) begin
         n_err++; $display("FAIL busy_drain_count: got %0d want 4", we_log.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (we_log[i] !== exp_q[i]) begin
               n_err++; $display("FAIL busy_drain_order[%0d]: got %h want %h", i, we_log[i], exp_q[i]);
            end
         end
         n_cmp++; if (we_cyc_q[3] - we_cyc_q[0] != 6) begin n_err++; $display("FAIL busy_throughput: got span %0d want 6", we_cyc_q[3] - we_cyc_q[0]); end
      end
   endtask

   task automatic test_reset_mid_read();
      apply_reset();
      strobe(1'b0, 1'b1, 20'h00200, 8'h00);
      strobe(1'b0, 1'b1, 20'h00123, 8'h00);
      reset = 1'b0;
      @(negedge GPU_CLK);
      n_cmp++; if (rd_collision !== 1'b1) begin n_err++; $display("FAIL mid_collision_pre: got %b want 1", rd_collision); end
      n_cmp++; if (ram_addr !== 20'h00200) begin n_err++; $display("FAIL mid_addr_pre: got %h want 00200", ram_addr); end
      repeat (2) @(posedge GPU_CLK);
      #1 reset = 1'b1;
      wait_cycles(8);
      n_cmp++; if (rdy_count != 0) begin n_err++; $display("FAIL mid_no_rdy: got %0d pulses want 0", rdy_count); end
      n_cmp++; if (ram_addr !== 20'h0) begin n_err++; $display("FAIL mid_ram_addr: got %h want 0", ram_addr); end
      n_cmp++; if (host_rData !== 8'h0) begin n_err++; $display("FAIL mid_rData: got %h want 0", host_rData); end
      n_cmp++; if (rd_collision !== 1'b0) begin n_err++; $display("FAIL mid_collision: got %b want 0", rd_collision); end
      n_cmp++; if (wr_overflow !== 1'b0) begin n_err++; $display("FAIL mid_overflow: got %b want 0", wr_overflow); end
   endtask

   task automatic test_collision();
      int n;
      apply_reset();
      strobe(1'b0, 1'b1, 20'h00123, 8'h00);
      n = last_n;
      strobe(1'b0, 1'b1, 20'h00200, 8'h00);
      wait_cycles(10);
      n_cmp++; if (rd_collision !== 1'b1) begin n_err++; $display("FAIL coll_flag: got %b want 1", rd_collision); end
      n_cmp++; if (rdy_count != 1) begin n_err++; $display("FAIL coll_pulses: got %0d want 1", rdy_count); end
      n_cmp++; if (rdy_cyc != n + 5) begin n_err++; $display("FAIL coll_latency: got cycle %0d want %0d", rdy_cyc, n + 5); end
      n_cmp++; if (rdy_data !== 8'h3C) begin n_err++; $display("FAIL coll_data: got %h want 3c", rdy_data); end
   endtask

   initial begin
      mem[15'h0123] = 8'h3C;
      mem[15'h0200] = 8'h9A;
      test_reset();
      test_write();
      test_read();
      test_write_then_read();
      test_out_of_range();
      test_busy_overflow();
      test_reset_mid_read();
      test_collision();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
